// File: rtl/term_cmd_encoder.sv
// rtl/term_cmd_encoder.sv - ASCII command line parser for the terminal-to-VGA command path
//
// Purpose: turns lines of the form "OOO AA<CR>" (three hex op_code digits,
// first digit 0-7, one space, two hex operand digits, CR) arriving one byte
// at a time into an op_code/a pair with a cmd_valid pulse; malformed lines or
// op_code values above OP_MAX produce a cmd_err pulse instead.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-low reset
//   rx_data    - received ASCII byte
//   rx_valid   - rx_data holds a byte
//   rx_ready   - byte can be accepted this cycle
//   op_code    - last accepted command code
//   a          - last accepted operand byte
//   cmd_valid  - one-cycle pulse: op_code/a updated
//   cmd_err    - one-cycle pulse: line rejected
//   tx_data    - echo byte
//   tx_valid   - tx_data holds an echo byte
//   tx_ready   - echo sink accepts tx_data
//
// Optional feature: define CMD_ECHO_EN to echo every accepted byte on tx_*.

module term_cmd_encoder #(
  parameter logic [10:0] OP_MAX = 11'h7FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [10:0] op_code,
  output logic [7:0]  a,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Each state names the byte the parser is waiting for. IDLE doubles as the
  // "first op_code digit" state, so OP1 is never entered but is decoded the
  // same way as IDLE for robustness.
  typedef enum logic [3:0] {
    IDLE, OP1, OP2, OP3, SEP, ARG1, ARG2, EOL, DISCARD
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  state_t      state_q, state_d;
  logic [10:0] op_acc_q, op_acc_d;
  logic [7:0]  arg_acc_q, arg_acc_d;
  logic [10:0] op_code_q, op_code_d;
  logic [7:0]  a_q, a_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_err_q, cmd_err_d;

  logic        accept;
  logic        hex_ok;
  logic [3:0]  hex_val;

  assign accept = rx_valid && rx_ready;

  // ASCII hex decode; 'A'..'F' and 'a'..'f' share the same low nibble.
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      hex_val = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      hex_val = rx_data[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_acc_d    = op_acc_q;
    arg_acc_d   = arg_acc_q;
    op_code_d   = op_code_q;
    a_d         = a_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;

    // LF is transparent everywhere.
    if (accept && rx_data != CHAR_LF) begin
      if (rx_data == CHAR_CR) begin
        case (state_q)
          IDLE, OP1: state_d = state_q;
          EOL: begin
            state_d = IDLE;
            if (op_acc_q <= OP_MAX) begin
              op_code_d   = op_acc_q;
              a_d         = arg_acc_q;
              cmd_valid_d = 1'b1;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          default: begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
          end
        endcase
      end else begin
        case (state_q)
          IDLE, OP1: begin
            if (hex_ok && !hex_val[3]) begin
              op_acc_d = {hex_val[2:0], 8'h00};
              state_d  = OP2;
            end else begin
              state_d = DISCARD;
            end
          end
          OP2: begin
            op_acc_d[7:4] = hex_val;
            state_d       = hex_ok ? OP3 : DISCARD;
          end
          OP3: begin
            op_acc_d[3:0] = hex_val;
            state_d       = hex_ok ? SEP : DISCARD;
          end
          SEP:  state_d = (rx_data == CHAR_SP) ? ARG1 : DISCARD;
          ARG1: begin
            arg_acc_d = {hex_val, 4'h0};
            state_d   = hex_ok ? ARG2 : DISCARD;
          end
          ARG2: begin
            arg_acc_d[3:0] = hex_val;
            state_d        = hex_ok ? EOL : DISCARD;
          end
          EOL:     state_d = DISCARD;
          DISCARD: state_d = DISCARD;
          default: state_d = DISCARD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_acc_q    <= 11'h000;
      arg_acc_q   <= 8'h00;
      op_code_q   <= 11'h000;
      a_q         <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_acc_q    <= op_acc_d;
      arg_acc_q   <= arg_acc_d;
      op_code_q   <= op_code_d;
      a_q         <= a_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign op_code   = op_code_q;
  assign a         = a_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;

`ifdef CMD_ECHO_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  // A new byte can only be accepted when the echo slot is free or draining
  // this cycle, so the echo register never drops a byte.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rx_data;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign rx_ready = !(tx_valid_q && !tx_ready);
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign rx_ready = 1'b1;
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_term_cmd_encoder.sv
// tb/tb_term_cmd_encoder.sv - testbench for term_cmd_encoder
//
// Two instances share one byte stream: dut0 with the default OP_MAX and
// dut1 with OP_MAX = 11'h010. A line-buffer model decides each line's fate.

module tb_term_cmd_encoder;

  localparam logic [10:0] OPMAX0 = 11'h7FF;
  localparam logic [10:0] OPMAX1 = 11'h010;
`ifdef CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        rx_ready0, rx_ready1;
  logic [10:0] op0, op1;
  logic [7:0]  a0, a1;
  logic        cv0, cv1, ce0, ce1;
  logic [7:0]  txd0, txd1;
  logic        txv0, txv1;

  term_cmd_encoder #(.OP_MAX(OPMAX0)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready0), .op_code(op0), .a(a0), .cmd_valid(cv0),
    .cmd_err(ce0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready)
  );

  term_cmd_encoder #(.OP_MAX(OPMAX1)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready1), .op_code(op1), .a(a1), .cmd_valid(cv1),
    .cmd_err(ce1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  line[$];
  logic [10:0] m_op[2];
  logic [7:0]  m_a[2];
  bit          m_cv[2];
  bit          m_ce[2];
  bit          m_txv;
  logic [7:0]  m_txd;
  logic [10:0] opmax[2];
  int cv0_cnt = 0, ce0_cnt = 0, cv1_cnt = 0, ce1_cnt = 0;

  initial begin
    opmax[0] = OPMAX0;
    opmax[1] = OPMAX1;
  end

  function automatic bit hexv(input logic [7:0] c, output logic [3:0] v);
    v = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin v = 4'(c - 8'h30); return 1'b1; end
    if (c >= 8'h41 && c <= 8'h46) begin v = 4'(c - 8'h37); return 1'b1; end
    if (c >= 8'h61 && c <= 8'h66) begin v = 4'(c - 8'h57); return 1'b1; end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit         acc, ok, hok;
    logic [3:0] dv[6];
    int         opv, av;
    acc = rx_valid && (!ECHO || !(m_txv && !tx_ready));
    if (!reset) begin
      line.delete();
      for (int i = 0; i < 2; i++) begin
        m_op[i] = 0; m_a[i] = 0; m_cv[i] = 0; m_ce[i] = 0;
      end
      m_txv = 0;
      m_txd = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin m_cv[i] = 0; m_ce[i] = 0; end
      if (acc && ECHO) begin
        m_txv = 1; m_txd = rx_data;
      end else if (tx_ready) begin
        m_txv = 0;
      end
      if (acc && rx_data != 8'h0A) begin
        if (rx_data == 8'h0D) begin
          if (line.size() != 0) begin
            ok = (line.size() == 6) && (line[3] == 8'h20);
            if (ok) begin
              for (int k = 0; k < 6; k++) begin
                if (k != 3) begin
                  hok = hexv(line[k], dv[k]);
                  ok = ok && hok;
                end
              end
            end
            if (ok && dv[0] > 4'd7) ok = 0;
            opv = 0; av = 0;
            if (ok) begin
              opv = dv[0] * 256 + dv[1] * 16 + dv[2];
              av  = dv[4] * 16 + dv[5];
            end
            for (int i = 0; i < 2; i++) begin
              if (ok && opv <= int'(opmax[i])) begin
                m_op[i] = 11'(opv); m_a[i] = 8'(av); m_cv[i] = 1;
              end else begin
                m_ce[i] = 1;
              end
            end
            line.delete();
          end
        end else begin
          line.push_back(rx_data);
        end
      end
    end
    #1;
    chk("op_code0", op0, m_op[0]);
    chk("a0", a0, m_a[0]);
    chk("cmd_valid0", cv0, m_cv[0]);
    chk("cmd_err0", ce0, m_ce[0]);
    chk("op_code1", op1, m_op[1]);
    chk("a1", a1, m_a[1]);
    chk("cmd_valid1", cv1, m_cv[1]);
    chk("cmd_err1", ce1, m_ce[1]);
    chk("tx_valid0", txv0, m_txv);
    chk("tx_data0", txd0, m_txd);
    chk("rx_ready0", rx_ready0, !(ECHO && m_txv && !tx_ready));
    chk("rx_ready1", rx_ready1, !(ECHO && m_txv && !tx_ready));
    if (cv0) cv0_cnt++;
    if (ce0) ce0_cnt++;
    if (cv1) cv1_cnt++;
    if (ce1) ce1_cnt++;
  end

  // ---------------- stimulus ----------------
  int stall = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (stall > 0) begin tx_ready = 1'b0; stall--; end
    else tx_ready = 1'b1;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    rx_data = d;
    rx_valid = 1'b1;
    while (rx_ready0 !== 1'b1 && n < 50) begin step(); n++; end
    if (n == 50) chk("handshake_timeout", rx_ready0, 1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(8'h0D);
    step();
    step();
  endtask

  int b_cv0, b_ce0, b_cv1, b_ce1;

  task automatic mark();
    b_cv0 = cv0_cnt; b_ce0 = ce0_cnt; b_cv1 = cv1_cnt; b_ce1 = ce1_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    step();
    step();
    chk("rst_op_code", op0, 11'h000);
    chk("rst_a", a0, 8'h00);
    chk("rst_cmd_valid", cv0, 0);
    chk("rst_cmd_err", ce0, 0);
    chk("rst_rx_ready", rx_ready0, 1);
    chk("rst_tx_valid", txv0, 0);
    chk("rst_tx_data", txd0, 8'h00);
    reset = 1'b1;
    step();

    // basic command; dut1 rejects it on OP_MAX
    mark();
    send_line("1A3 5F");
    chk("t1_op", op0, 11'h1A3);
    chk("t1_a", a0, 8'h5F);
    chk("t1_cv_pulses", cv0_cnt - b_cv0, 1);
    chk("t1_model_op", m_op[0], 11'h1A3);
    chk("t1_dut1_err", ce1_cnt - b_ce1, 1);

    // illegal digit
    mark();
    send_line("0g1 00");
    chk("t2_err_pulses", ce0_cnt - b_ce0, 1);
    chk("t2_cv_pulses", cv0_cnt - b_cv0, 0);
    chk("t2_op_kept", op0, 11'h1A3);
    chk("t2_a_kept", a0, 8'h5F);

    // OP_MAX boundary on dut1
    mark();
    send_line("011 00");
    chk("t3_dut1_err", ce1_cnt - b_ce1, 1);
    chk("t3_dut0_valid", cv0_cnt - b_cv0, 1);
    mark();
    send_line("010 FF");
    chk("t3_dut1_valid", cv1_cnt - b_cv1, 1);
    chk("t3_op1", op1, 11'h010);
    chk("t3_a1", a1, 8'hFF);
    chk("t3_model_a1", m_a[1], 8'hFF);

    // CR/LF ignored in IDLE
    mark();
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h0A);
    send_line("00a 0c");
    chk("t4_op", op0, 11'h00A);
    chk("t4_a", a0, 8'h0C);
    chk("t4_cv_pulses", cv0_cnt - b_cv0, 1);
    chk("t4_err_pulses", ce0_cnt - b_ce0, 0);

    // first digit above 7, upper op_code boundary, short line, trailing junk, LF mid-line
    mark();
    send_line("8AB CD");
    chk("t5_first_digit_err", ce0_cnt - b_ce0, 1);
    send_line("7ff ff");
    chk("t5_max_op", op0, 11'h7FF);
    chk("t5_max_a", a0, 8'hFF);
    mark();
    send_line("12");
    send_line("123 45x");
    chk("t5_err_pulses", ce0_cnt - b_ce0, 2);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h0A);
    send_line("3 45");
    chk("t5_lf_op", op0, 11'h123);
    chk("t5_lf_a", a0, 8'h45);

    // reset mid-line
    send_str("7FF");
    reset = 1'b0;
    step();
    reset = 1'b1;
    mark();
    send_line(" 01");
    chk("t6_cv_pulses", cv0_cnt - b_cv0, 0);
    chk("t6_err_pulses", ce0_cnt - b_ce0, 1);
    chk("t6_op", op0, 11'h000);
    chk("t6_a", a0, 8'h00);

    // echo back-pressure
    tx_ready = 1'b0;
    stall = 5;
    send_byte(8'h41);
    for (int i = 0; i < 5; i++) begin
      chk("t7_tx_data", txd0, ECHO ? 8'h41 : 8'h00);
      chk("t7_tx_valid", txv0, ECHO);
      chk("t7_rx_ready", rx_ready0, !ECHO);
      if (i < 4) step();
    end
    step();
    chk("t7_rx_ready_release", rx_ready0, 1);
    mark();
    send_line("");
    chk("t7_err_pulses", ce0_cnt - b_ce0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_cmd_encoder.md
TERM_CMD_ENCODER -- requirements
Module: term_cmd_encoder

Interface
REQ-001 SHALL have parameter OP_MAX, default 11'h7FF: highest legal op_code value; a parsed op_code above it is a command error.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port rx_data, input, 8: ASCII byte from the serial receiver.
REQ-005 SHALL have port rx_valid, input, 1: rx_data holds a byte.
REQ-006 SHALL have port rx_ready, output, 1: block can accept a byte this cycle.
REQ-007 SHALL have port op_code, output, 11: last successfully parsed command code, fed to the VGA command decoder.
REQ-008 SHALL have port a, output, 8: last successfully parsed operand byte.
REQ-009 SHALL have port cmd_valid, output, 1: one-cycle pulse marking new op_code/a.
REQ-010 SHALL have port cmd_err, output, 1: one-cycle pulse marking a rejected line.
REQ-011 SHALL have port tx_data, output, 8: echo byte (CMD_ECHO_EN only).
REQ-012 SHALL have port tx_valid, output, 1: tx_data holds an echo byte.
REQ-013 SHALL have port tx_ready, input, 1: echo sink accepts tx_data.

Function
REQ-014 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both 1.
REQ-015 SHALL parse lines of the form: three hex digits (op_code, MSB first), one space (0x20), two hex digits (a, MSB first), CR (0x0D).
REQ-016 SHALL accept hex digits 0-9, A-F, a-f; the first op_code digit SHALL be 0-7.
REQ-017 SHALL use FSM states IDLE, OP1, OP2, OP3, SEP, ARG1, ARG2, EOL, DISCARD.
REQ-018 SHALL, in IDLE, ignore CR and LF (0x0A) and move to OP2 on a legal first digit.
REQ-019 SHALL advance one state per legal accepted byte: OP2->OP3->SEP->ARG1->ARG2->EOL.
REQ-020 SHALL enter DISCARD on any illegal byte in any state other than DISCARD, except CR.
REQ-021 SHALL, on an accepted CR in any state other than IDLE and EOL, return to IDLE and pulse cmd_err the next cycle.
REQ-022 SHALL ignore LF in every state except IDLE, where it is also ignored.
REQ-023 SHALL, on CR accepted in EOL with parsed op_code <= OP_MAX, update op_code and a and pulse cmd_valid, all on the next cycle, then return to IDLE.
REQ-024 SHALL, on CR accepted in EOL with op_code > OP_MAX, leave op_code/a unchanged and pulse cmd_err.
REQ-025 SHALL hold op_code and a stable between cmd_valid pulses.
REQ-026 SHALL never assert cmd_valid and cmd_err in the same cycle.
REQ-027 SHALL keep rx_ready = 1 whenever the echo path is disabled.

Reset
REQ-028 SHALL, when reset = 0 at a clock edge, set state IDLE, op_code 0, a 0, cmd_valid 0, cmd_err 0, tx_valid 0, tx_data 0, rx_ready 1, and clear partial digits.
REQ-029 SHALL discard any partially received line when reset occurs mid-line, with no cmd_valid or cmd_err pulse.

Configuration
REQ-030 SHALL, with macro CMD_ECHO_EN defined, register every accepted byte onto tx_data with tx_valid = 1 the next cycle, holding both until tx_ready = 1.
REQ-031 SHALL, with CMD_ECHO_EN defined, drive rx_ready = 0 while tx_valid = 1 and tx_ready = 0.
REQ-032 SHALL, without CMD_ECHO_EN, tie tx_data to 0 and tx_valid to 0, ignore tx_ready, and follow REQ-027.

Verification
REQ-033 SHALL cover: send "1A3 5F\r" -> one cycle after CR, op_code = 11'h1A3, a = 8'h5F, cmd_valid pulses once.
REQ-034 SHALL cover: send "0g1 00\r" -> cmd_err pulses once after CR; op_code and a keep prior values.
REQ-035 SHALL cover: OP_MAX = 11'h010, send "011 00\r" -> cmd_err; then send "010 FF\r" -> cmd_valid with op_code = 11'h010, a = 8'hFF.
REQ-036 SHALL cover: send "7FF" then assert reset = 0 for one cycle, then send " 01\r" -> no cmd_valid; cmd_err pulses on CR; outputs remain 0.
REQ-037 SHALL cover: with CMD_ECHO_EN, tx_ready = 0 for 5 cycles after first byte 'A' -> tx_data = 8'h41 held, rx_ready = 0 until tx_ready = 1.
REQ-038 SHALL cover: send "\r\n\n00a 0c\r" -> CR/LF ignored in IDLE; cmd_valid with op_code = 11'h00A, a = 8'h0C.
